// File: rtl/text_plotter.sv
// Text sweep sequencer: walks every pixel of a string of character cells,
// samples the glyph decoder and forwards lit pixels to the framebuffer writer.
module text_plotter #(
    parameter int CELL_W    = 8,
    parameter int CELL_H    = 10,
    parameter int MAX_CHARS = 16,
    localparam int IW = $clog2(MAX_CHARS),
    localparam int LW = IW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    origin_x,
    input  logic [7:0]    origin_y,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] char_index,
    output logic [7:0]    char_x,
    output logic [7:0]    char_y,
    output logic [7:0]    flush_x,
    output logic [7:0]    flush_y,
    input  logic          glyph_enable,
    input  logic [5:0]    glyph_colour,
    output logic          plot,
    input  logic          plot_ready,
    output logic [7:0]    plot_x,
    output logic [7:0]    plot_y,
    output logic [5:0]    plot_colour
);

    localparam int CW = $clog2(CELL_W);
    localparam int RW = $clog2(CELL_H);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    ox_q, ox_d, oy_q, oy_d;
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          plot_q, plot_d;
    logic [7:0]    px_q, px_d, py_q, py_d;
    logic [5:0]    pc_q, pc_d;

    logic last_col, last_row, last_px, adv;

    assign char_x  = ox_q + 8'(CELL_W * int'(idx_q));
    assign char_y  = oy_q;
    assign flush_x = char_x + 8'(col_q);
    assign flush_y = oy_q + 8'(row_q);

    assign char_index  = idx_q;
    assign busy        = (state_q == SCAN) || (state_q == EMIT);
    assign done        = (state_q == DONE);
    assign plot        = plot_q;
    assign plot_x      = px_q;
    assign plot_y      = py_q;
    assign plot_colour = pc_q;

    assign last_col = (col_q == CW'(CELL_W - 1));
    assign last_row = (row_q == RW'(CELL_H - 1));
    assign last_px  = last_col && last_row && ({1'b0, idx_q} == len_q - LW'(1));

    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        len_d   = len_q;
        col_d   = col_q;
        row_d   = row_q;
        idx_d   = idx_q;
        plot_d  = plot_q;
        px_d    = px_q;
        py_d    = py_q;
        pc_d    = pc_q;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ox_d    = origin_x;
                    oy_d    = origin_y;
                    len_d   = (length > LW'(MAX_CHARS)) ? LW'(MAX_CHARS) : length;
                    col_d   = '0;
                    row_d   = '0;
                    idx_d   = '0;
                    state_d = (length == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (glyph_enable) begin
                    plot_d  = 1'b1;
                    px_d    = flush_x;
                    py_d    = flush_y;
                    pc_d    = glyph_colour;
                    state_d = EMIT;
                end else begin
                    adv = 1'b1;
                end
            end
            EMIT: begin
                if (plot_ready) begin
                    plot_d = 1'b0;
                    adv    = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // col fastest, then row, then character
        if (adv) begin
            state_d = last_px ? DONE : SCAN;
            col_d   = last_col ? '0 : col_q + CW'(1);
            if (last_col) begin
                row_d = last_row ? '0 : row_q + RW'(1);
                if (last_row) idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            len_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            idx_q   <= '0;
            plot_q  <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            len_q   <= len_d;
            col_q   <= col_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            plot_q  <= plot_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_text_plotter.sv
// Directed bench for text_plotter with a small behavioural glyph decoder.
module tb_text_plotter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] origin_x = '0;
    logic [7:0] origin_y = '0;
    logic [4:0] length = '0;
    logic       busy, done, plot;
    logic [3:0] char_index;
    logic [7:0] char_x, char_y, flush_x, flush_y;
    logic       glyph_enable;
    logic [5:0] glyph_colour;
    logic       plot_ready = 1'b1;
    logic [7:0] plot_x, plot_y;
    logic [5:0] plot_colour;

    int checks = 0;
    int errors = 0;
    int mode = 0;

    text_plotter dut (
        .clk(clk), .reset(reset), .start(start),
        .origin_x(origin_x), .origin_y(origin_y), .length(length),
        .busy(busy), .done(done), .char_index(char_index),
        .char_x(char_x), .char_y(char_y),
        .flush_x(flush_x), .flush_y(flush_y),
        .glyph_enable(glyph_enable), .glyph_colour(glyph_colour),
        .plot(plot), .plot_ready(plot_ready),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour)
    );

    always #5 clk = ~clk;

    // mode 0 blank, mode 1 first 23 cells lit, mode 2 cell (0,0) of each char lit
    logic [7:0]  gcol, grow;
    logic [15:0] gp;
    always_comb begin
        gcol = flush_x - char_x;
        grow = flush_y - char_y;
        gp   = {8'd0, grow} * 16'd8 + {8'd0, gcol};
        glyph_enable = 1'b0;
        glyph_colour = '0;
        case (mode)
            1: begin
                glyph_enable = (gp < 16'd23);
                glyph_colour = gp[5:0];
            end
            2: begin
                glyph_enable = (gcol == 8'd0) && (grow == 8'd0);
                glyph_colour = {2'b00, char_index};
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input logic [7:0] ox, input logic [7:0] oy, input logic [4:0] len,
                       input int md, input int stall, input int exp_done,
                       input int exp_plots, input bit fchk, input int glitch);
        int done_at, done_cnt, busy_cnt, plots, hold, idx;
        bit in_emit;
        logic [7:0] hx, hy, ex, ey;
        logic [5:0] hc, ec;
        done_at = 0; done_cnt = 0; busy_cnt = 0; plots = 0; hold = 0;
        in_emit = 1'b0;
        hx = '0; hy = '0; hc = '0;
        mode = md;
        @(negedge clk);
        origin_x = ox; origin_y = oy; length = len;
        start = 1'b1; plot_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= exp_done + 20; n++) begin
            @(negedge clk);
            if (n == glitch) begin
                start = 1'b1; origin_x = 8'd99; origin_y = 8'd77; length = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (fchk && busy) begin
                idx = (n - 1) / 80;
                ex = ox + 8'(8 * idx + (n - 1) % 8);
                ey = oy + 8'(((n - 1) / 8) % 10);
                check("flush_x", 32'(flush_x), 32'(ex));
                check("flush_y", 32'(flush_y), 32'(ey));
                check("char_index", 32'(char_index), 32'(idx[3:0]));
            end
            if (plot) begin
                if (!in_emit) begin
                    in_emit = 1'b1;
                    hold = 0;
                    if (md == 2) begin
                        ex = ox + 8'(8 * plots);
                        ey = oy;
                        check("plot_char_index", 32'(char_index), 32'(plots));
                    end else begin
                        ex = ox + 8'(plots % 8);
                        ey = oy + 8'(plots / 8);
                    end
                    ec = 6'(plots);
                    check("plot_x", 32'(plot_x), 32'(ex));
                    check("plot_y", 32'(plot_y), 32'(ey));
                    check("plot_colour", 32'(plot_colour), 32'(ec));
                    hx = plot_x; hy = plot_y; hc = plot_colour;
                    plots++;
                end else begin
                    check("stall_x", 32'(plot_x), 32'(hx));
                    check("stall_y", 32'(plot_y), 32'(hy));
                    check("stall_colour", 32'(plot_colour), 32'(hc));
                end
                plot_ready = (hold >= stall);
                hold++;
            end else begin
                in_emit = 1'b0;
                plot_ready = 1'b1;
            end
            if (done_at != 0 && n >= done_at + 3) break;
        end
        start = 1'b0;
        check("done_cycle", 32'(done_at), 32'(exp_done));
        check("done_count", 32'(done_cnt), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'(exp_done - 1));
        check("plot_count", 32'(plots), 32'(exp_plots));
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_plot_x", 32'(plot_x), 32'd0);
        check("rst_char_index", 32'(char_index), 32'd0);
        check("rst_flush_x", 32'(flush_x), 32'd0);
        reset = 1'b0;

        // blank glyph, single char
        run(8'd10, 8'd20, 5'd1, 0, 0, 81, 0, 1'b1, 0);
        // 23 lit cells, ready always high
        run(8'd10, 8'd20, 5'd1, 1, 0, 104, 23, 1'b0, 0);
        // same with 5-cycle stall on every plot
        run(8'd10, 8'd20, 5'd1, 1, 5, 219, 23, 1'b0, 0);
        // x wraps past 255
        run(8'd250, 8'd0, 5'd3, 2, 0, 244, 3, 1'b0, 0);
        // empty string
        run(8'd10, 8'd20, 5'd0, 0, 0, 1, 0, 1'b0, 0);
        // start during sweep must be ignored
        run(8'd10, 8'd20, 5'd1, 0, 0, 81, 0, 1'b1, 30);
        // length above the maximum is clamped to 16 chars
        run(8'd3, 8'd5, 5'd20, 0, 0, 1281, 0, 1'b1, 0);

        // reset while a plot is pending
        mode = 1;
        @(negedge clk);
        origin_x = 8'd10; origin_y = 8'd20; length = 5'd1;
        start = 1'b1; plot_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = plot;
        end
        check("pre_rst_plot", 32'(seen), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_plot", 32'(plot), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        @(negedge clk);
        check("async_plot_x", 32'(plot_x), 32'd0);
        reset = 1'b0;
        plot_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        // new sweep after reset starts from char 0
        run(8'd250, 8'd0, 5'd3, 2, 0, 244, 3, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
